// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR of two N-bit operands, one bit per clock, start/done handshake.
// Optional zero/parity result flags are enabled with `define SERIAL_LOGIC_FLAGS_EN.
module serial_logic_unit #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] C,
    output logic         busy,
    output logic         done
`ifdef SERIAL_LOGIC_FLAGS_EN
    ,
    output logic         zero,
    output logic         parity
`endif
);

    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    sa_q, sa_d;
    logic [N-1:0]    sb_q, sb_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [N-1:0]    c_q, c_d;
    logic [1:0]      sop_q, sop_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            res_bit;

    always_comb begin
        unique case (sop_q)
            2'b00:   res_bit = sa_q[0] & sb_q[0];
            2'b01:   res_bit = sa_q[0] | sb_q[0];
            2'b10:   res_bit = sa_q[0] ^ sb_q[0];
            default: res_bit = ~(sa_q[0] | sb_q[0]);
        endcase
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        sop_d   = sop_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    sop_d   = op;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d  = {1'b0, sa_q[N-1:1]};
                sb_d  = {1'b0, sb_q[N-1:1]};
                // LSB enters first and ends up at sr[0] after N shifts
                sr_d  = {res_bit, sr_q[N-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    c_d     = sr_d;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= '0;
            sop_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            sop_q   <= sop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign C    = c_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

`ifdef SERIAL_LOGIC_FLAGS_EN
    logic zero_q, parity_q;

    // Flags track C: computed from the final result on the edge that loads C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else if (state_q == StRun && cnt_q == CntW'(N - 1)) begin
            zero_q   <= (c_d == '0);
            parity_q <= ^c_d;
        end
    end

    assign zero   = zero_q;
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed self-checking bench for serial_logic_unit (N=8).
// Flag checks are compiled in when SERIAL_LOGIC_FLAGS_EN is defined.
module tb_serial_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic       busy;
    logic       done;
`ifdef SERIAL_LOGIC_FLAGS_EN
    logic       zero;
    logic       parity;
`endif

    int errors = 0;
    int checks = 0;

    serial_logic_unit #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .C     (C),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_LOGIC_FLAGS_EN
        ,
        .zero  (zero),
        .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done; lat counts cycles after the start edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                         output logic [7:0] c, output int lat);
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        c = C;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        #1;
        checks++;
        if (C !== 8'h00) begin errors++; $display("FAIL reset_c: got %h want 00", C); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef SERIAL_LOGIC_FLAGS_EN
        checks++;
        if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++;
        if (parity !== 1'b0) begin errors++; $display("FAIL reset_par: got %b want 0", parity); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_and_latency;
        int nbusy = 0;
        int ndone = 0;
        @(negedge clk);
        A = 8'hF0; B = 8'hAA; op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (nbusy !== 8) begin errors++; $display("FAIL and_busy_cycles: got %0d want 8", nbusy); end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL and_early_done: got %0d want 0", ndone); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL and_done_pulse: got done=%b busy=%b want 1 0", done, busy);
        end
        checks++;
        if (C !== 8'hA0) begin errors++; $display("FAIL and_result: got %h want a0", C); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL and_done_low: got %b want 0", done); end
        checks++;
        if (C !== 8'hA0) begin errors++; $display("FAIL and_hold: got %h want a0", C); end
    endtask

    task automatic test_ops;
        logic [7:0] exp_c [4] = '{8'h0C, 8'h3F, 8'h33, 8'hC0};
        logic [7:0] c;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(8'h0F, 8'h3C, 2'(i), c, lat);
            checks++;
            if (c !== exp_c[i]) begin
                errors++; $display("FAIL ops_result op=%0d: got %h want %h", i, c, exp_c[i]);
            end
            checks++;
            if (lat !== 9) begin errors++; $display("FAIL ops_latency op=%0d: got %0d want 9", i, lat); end
        end
    endtask

    task automatic test_start_ignored;
        int ndone = 0;
        logic [7:0] c_at_done = 'x;
        @(negedge clk);
        A = 8'hFF; B = 8'h0F; op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'h55;
        @(negedge clk);
        @(negedge clk);
        A = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) begin ndone++; c_at_done = C; end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ign_pulses: got %0d want 1", ndone); end
        checks++;
        if (c_at_done !== 8'h0F) begin errors++; $display("FAIL ign_result: got %h want 0f", c_at_done); end
        checks++;
        if (C !== 8'h0F) begin errors++; $display("FAIL ign_hold: got %h want 0f", C); end
    endtask

    task automatic test_reset_mid_run;
        int ndone = 0;
        logic [7:0] c;
        int lat;
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; op = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (C !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got C=%h busy=%b done=%b want 00 0 0", C, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", ndone); end
        checks++;
        if (C !== 8'h00) begin errors++; $display("FAIL rst_c_stays: got %h want 00", C); end
        do_op(8'h81, 8'hFF, 2'b00, c, lat);
        checks++;
        if (c !== 8'h81) begin errors++; $display("FAIL rst_next_op: got %h want 81", c); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL rst_next_lat: got %0d want 9", lat); end
    endtask

`ifdef SERIAL_LOGIC_FLAGS_EN
    task automatic test_flags;
        logic [7:0] c;
        int lat;
        do_op(8'h55, 8'hAA, 2'b00, c, lat);
        checks++;
        if (c !== 8'h00 || zero !== 1'b1 || parity !== 1'b0) begin
            errors++; $display("FAIL flags_and: got C=%h z=%b p=%b want 00 1 0", c, zero, parity);
        end
        do_op(8'h55, 8'hAA, 2'b10, c, lat);
        checks++;
        if (c !== 8'hFF || zero !== 1'b0 || parity !== 1'b0) begin
            errors++; $display("FAIL flags_xor: got C=%h z=%b p=%b want ff 0 0", c, zero, parity);
        end
        do_op(8'h01, 8'h00, 2'b01, c, lat);
        checks++;
        if (c !== 8'h01 || zero !== 1'b0 || parity !== 1'b1) begin
            errors++; $display("FAIL flags_or: got C=%h z=%b p=%b want 01 0 1", c, zero, parity);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_and_latency();
        test_ops();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SERIAL_LOGIC_FLAGS_EN
        test_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
